lcd_text_ctrl: RTL and testbench
================================

LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

Interface
REQ-001 SHALL have parameter CNT1MS, default 100_000: clk cycles per tick.
REQ-002 SHALL have parameter COLS, default 16: characters per row, range 8..20.
REQ-003 SHALL have parameter ROWS, default 2: display rows, range 1..4.
REQ-004 SHALL have parameter BUS4, default 0: 0 selects the 8-bit LCD bus, 1 selects the 4-bit nibble bus.
REQ-005 SHALL have port clk  in  1: single clock; the block SHALL use one clock only.
REQ-006 SHALL have port resetn  in  1: reset, asynchronous and active-low.
REQ-007 SHALL have port wr_en  in  1: text-buffer write strobe.
REQ-008 SHALL have port wr_row  in  2: target row.
REQ-009 SHALL have port wr_col  in  5: target column.
REQ-010 SHALL have port wr_char  in  8: CGROM character code.
REQ-011 SHALL have port cmd_valid  in  1: user command request.
REQ-012 SHALL have port cmd_code  in  8: raw HD44780 command byte.
REQ-013 SHALL have port cmd_ready  out  1: command accept.
REQ-014 SHALL have port init_done  out  1: init sequence complete.
REQ-015 SHALL have port frame_done  out  1: one-cycle pulse at the end of each full refresh.
REQ-016 SHALL have ports lcd_e out 1, lcd_rs out 1, lcd_rw out 1 and lcd_data out 8, forming the LCD bus.

Function
REQ-017 SHALL generate a tick every CNT1MS cycles and a 2-bit phase counter that advances on each tick.
REQ-018 SHALL begin a slot on each tick at which the phase wraps from 3 to 0, so one slot lasts 4*CNT1MS cycles.
REQ-019 SHALL begin the first slot on the 4th tick after reset release, giving at least 4 ms of power-on wait.
REQ-020 SHALL register lcd_rs and lcd_data at slot start and hold them for the whole slot.
REQ-021 SHALL drive lcd_e high only while phase==1, and SHALL hold lcd_rw at 0 constantly.
REQ-022 SHALL, in 8-bit mode, issue one transaction per slot.
REQ-023 SHALL, in 4-bit mode, issue each byte as two slots: high nibble first, nibble on lcd_data[7:4], lcd_data[3:0]=0.
REQ-024 SHALL issue the init sequence 0x38,0x08,0x01,0x06,0x0C when BUS4=0.
REQ-025 SHALL, when BUS4=1, issue single nibbles 0x3,0x3,0x3,0x2 (one slot each), then bytes 0x28,0x08,0x01,0x06,0x0C.
REQ-026 SHALL assert init_done from the slot after the last init slot and hold it until the next reset.
REQ-027 SHALL use FSM states INIT -> ROW_ADDR -> ROW_CHAR -> (next row ROW_ADDR | CMD | ROW_ADDR of row 0), repeating forever.
REQ-028 SHALL, in ROW_ADDR, send rs=0 and 0x80|base, with base = 0x00/0x40/0x14/0x54 for rows 0..3.
REQ-029 SHALL, in ROW_CHAR, send rs=1 with the buffer byte for columns 0..COLS-1, one byte per transaction.
REQ-030 SHALL make a frame ROWS*(COLS+1) transactions long; 34 slots for 2x16 in 8-bit mode.
REQ-031 SHALL pulse frame_done on the slot-start cycle that follows the last character of the last row.
REQ-032 SHALL hold a text buffer of ROWS*COLS bytes, reset to 0x20.
REQ-033 SHALL write the buffer on any cycle with wr_en=1, including during INIT, and SHALL ignore writes with wr_row>=ROWS or wr_col>=COLS.
REQ-034 SHALL sample the buffer byte at slot start; a write to the same cell in that same cycle is sent next frame.
REQ-035 SHALL drive cmd_ready = init_done & ~cmd_pending.
REQ-036 SHALL capture cmd_code into cmd_pending on cmd_valid&cmd_ready.
REQ-037 SHALL issue a pending command (rs=0) in a CMD state inserted after the current row completes, never mid-row, then resume ROW_ADDR of the next row.
REQ-038 SHALL deassert cmd_ready while a command is pending.

Reset
REQ-039 SHALL, on resetn low at any time, immediately force lcd_e=0, lcd_rs=0, lcd_data=0x00, init_done=0, frame_done=0 and cmd_ready=0.
REQ-040 SHALL, on reset, clear the phase and tick counters, refill the buffer with 0x20, drop cmd_pending, and return the FSM to INIT.
REQ-041 SHALL, after reset mid-frame or mid-init, restart the full init sequence.

Structure
REQ-042 SHALL place command constants, row base addresses, both init sequences and the state enumeration in package lcd_pkg.
REQ-043 SHALL implement tick and phase generation as sub-module lcd_tick_gen (parameter CNT1MS; outputs tick, phase, slot_start).

Verification (CNT1MS=4, so one slot = 16 cycles)
REQ-044 SHALL cover: reset release with BUS4=0 -> first lcd_e rise at the 4th tick after release plus one phase, lcd_data=0x38, and init_done high after 5 slots.
REQ-045 SHALL cover: BUS4=1 -> lcd_data[7:4] sequence 3,3,3,2,2,8,0,8,0,1,0,6,0,C, and init_done after 14 slots.
REQ-046 SHALL cover: writing 'A'(0x41) to row1 col0 after init -> row1 transactions are 0xC0 (rs=0) then 0x41 (rs=1), and the other cells are 0x20.
REQ-047 SHALL cover: cmd_valid with 0x01 accepted mid-row0 -> cmd_ready low, 0x01 sent right after row0's last char, then 0xC0, then cmd_ready high again.
REQ-048 SHALL cover: writes with wr_row=2 (ROWS=2) or wr_col=16 -> no buffer change and the frame is identical.
REQ-049 SHALL cover: resetn pulse mid-ROW_CHAR -> lcd_e low the same cycle, buffer all 0x20, init repeated from 0x38, and frame_done every 34 slots thereafter.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 command constants, row bases, init sequences and FSM states
//   Exports: CMD_* command bytes, ROW_BASE, INIT8/INIT4 sequences, state_t, init_byte()
package lcd_pkg;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_ENTRY     = 8'h06;
   localparam logic [7:0] CMD_DISP_OFF  = 8'h08;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_FUNC4     = 8'h28;
   localparam logic [7:0] CMD_FUNC8     = 8'h38;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
   localparam logic [0:3][7:0] ROW_BASE = {8'h00, 8'h40, 8'h14, 8'h54};
   localparam int INIT8_LEN     = 5;
   localparam int INIT4_LEN     = 9;
   localparam int INIT4_NIBBLES = 4;
   localparam logic [0:4][7:0] INIT8 = {CMD_FUNC8, CMD_DISP_OFF, CMD_CLEAR, CMD_ENTRY, CMD_DISP_ON};
   // The first four 4-bit entries are wake-up nibbles carried in the high nibble, sent as one slot each
   localparam logic [0:8][7:0] INIT4 = {8'h30, 8'h30, 8'h30, 8'h20, CMD_FUNC4, CMD_DISP_OFF,
                                        CMD_CLEAR, CMD_ENTRY, CMD_DISP_ON};
   typedef enum logic [1:0] {ST_INIT, ST_ROW_ADDR, ST_ROW_CHAR, ST_CMD} state_t;
   function automatic logic [7:0] init_byte(input logic bus4, input logic [3:0] i);
      return bus4 ? INIT4[i] : INIT8[i];
   endfunction
endpackage

// File: rtl/lcd_tick_gen.sv
// lcd_tick_gen: CNT1MS tick, 2-bit phase counter and slot-start strobe
//   clk, resetn (async active-low) in; tick, phase[1:0], slot_start out
module lcd_tick_gen #(
   parameter int CNT1MS = 100_000
) (
   input  logic       clk,
   input  logic       resetn,
   output logic       tick,
   output logic [1:0] phase,
   output logic       slot_start
);
   localparam int W = CNT1MS > 1 ? $clog2(CNT1MS) : 1;
   logic [W-1:0] cnt;
   assign tick       = cnt == W'(CNT1MS - 1);
   assign slot_start = tick && phase == 2'd3;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         phase <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) phase <= phase + 2'd1;
      end
   end
endmodule

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: HD44780 text refresher with init sequence, text buffer and command insertion
//   clk, resetn (async active-low) in
//   wr_en, wr_row[1:0], wr_col[4:0], wr_char[7:0] in: text-buffer write port
//   cmd_valid, cmd_code[7:0] in / cmd_ready out: raw command handshake
//   init_done, frame_done out: status; lcd_e, lcd_rs, lcd_rw, lcd_data[7:0] out: LCD bus
module lcd_text_ctrl
   import lcd_pkg::*;
#(
   parameter int CNT1MS = 100_000,
   parameter int COLS   = 16,
   parameter int ROWS   = 2,
   parameter int BUS4   = 0
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       wr_en,
   input  logic [1:0] wr_row,
   input  logic [4:0] wr_col,
   input  logic [7:0] wr_char,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_code,
   output logic       cmd_ready,
   output logic       init_done,
   output logic       frame_done,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);
   localparam int NCELL     = ROWS * COLS;
   localparam int AW        = $clog2(NCELL);
   localparam int LAST_INIT = BUS4 != 0 ? INIT4_LEN - 1 : INIT8_LEN - 1;
   localparam bit NIB       = BUS4 != 0;
   logic          tick, slot_start;
   logic [1:0]    phase;
   state_t        state;
   logic [3:0]    idx;
   logic [1:0]    row;
   logic [4:0]    col;
   logic          half, active, eof, pend;
   logic [3:0]    nib_lo;
   logic [7:0]    cmd_q;
   logic [7:0]    text [NCELL];
   logic [7:0]    cur_byte;
   logic          cur_single, adv, wr_ok, last_col;
   logic [AW-1:0] rd_idx, wr_idx;
   logic [1:0]    next_row;
   lcd_tick_gen #(.CNT1MS(CNT1MS)) u_tick (
      .clk       (clk),
      .resetn    (resetn),
      .tick      (tick),
      .phase     (phase),
      .slot_start(slot_start)
   );
   assign lcd_rw     = 1'b0;
   assign cmd_ready  = init_done & ~pend;
   // eof marks that the transaction just issued was the last character of the last row
   assign frame_done = slot_start & eof;
   assign rd_idx     = AW'(int'(row) * COLS + int'(col));
   assign wr_idx     = AW'(int'(wr_row) * COLS + int'(wr_col));
   assign wr_ok      = int'(wr_row) < ROWS && int'(wr_col) < COLS;
   assign last_col   = int'(col) == COLS - 1;
   assign next_row   = int'(row) == ROWS - 1 ? 2'd0 : row + 2'd1;
   assign cur_byte   = state == ST_INIT     ? init_byte(NIB, idx) :
                       state == ST_ROW_ADDR ? (CMD_SET_DDRAM | ROW_BASE[row]) :
                       state == ST_ROW_CHAR ? text[rd_idx] : cmd_q;
   assign cur_single = NIB && state == ST_INIT && idx < 4'(INIT4_NIBBLES);
   // A byte is consumed after its only slot (8-bit, wake-up nibble) or its low-nibble slot
   assign adv        = !NIB || half || cur_single;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NCELL; i++) text[i] <= 8'h20;
         state     <= ST_INIT;
         idx       <= '0;
         row       <= '0;
         col       <= '0;
         half      <= 1'b0;
         nib_lo    <= '0;
         active    <= 1'b0;
         eof       <= 1'b0;
         pend      <= 1'b0;
         cmd_q     <= '0;
         init_done <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= '0;
      end else begin
         if (wr_en && wr_ok) text[wr_idx] <= wr_char;
         if (cmd_valid && cmd_ready) begin
            pend  <= 1'b1;
            cmd_q <= cmd_code;
         end
         // Phase becomes 1 on this tick, so the strobe covers exactly phase 1 of an active slot
         if (tick) lcd_e <= active && phase == 2'd0;
         if (slot_start) begin
            active <= 1'b1;
            eof    <= 1'b0;
            lcd_rs <= state == ST_ROW_CHAR;
            // The low nibble is latched with the high one so both halves come from one buffer sample
            lcd_data <= !NIB ? cur_byte : half ? {nib_lo, 4'h0} : {cur_byte[7:4], 4'h0};
            nib_lo   <= cur_byte[3:0];
            half     <= NIB && !half && !cur_single;
            if (state != ST_INIT) init_done <= 1'b1;
            if (adv) begin
               case (state)
                  ST_INIT:
                     if (idx == 4'(LAST_INIT)) begin
                        state <= ST_ROW_ADDR;
                        row   <= '0;
                     end else idx <= idx + 4'd1;
                  ST_ROW_ADDR: begin
                     state <= ST_ROW_CHAR;
                     col   <= '0;
                  end
                  ST_ROW_CHAR:
                     if (last_col) begin
                        eof   <= int'(row) == ROWS - 1;
                        row   <= next_row;
                        state <= pend ? ST_CMD : ST_ROW_ADDR;
                     end else col <= col + 5'd1;
                  default: begin
                     pend  <= 1'b0;
                     state <= ST_ROW_ADDR;
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb_lcd_text_ctrl: scoreboard bench for lcd_text_ctrl in 8-bit and 4-bit bus modes
module tb_lcd_text_ctrl;
   typedef struct packed {logic rs; logic [7:0] d;} txn_t;
   logic       clk, resetn, wr_en, cmd_valid;
   logic [1:0] wr_row;
   logic [4:0] wr_col;
   logic [7:0] wr_char, cmd_code;
   logic       e8, rs8, rw8, id8, fd8, cr8;
   logic [7:0] d8;
   logic       e4, rs4, rw4, id4, fd4, cr4;
   logic [7:0] d4;
   txn_t       q8[$], q4[$];
   txn_t       t8, t4;
   logic       e8_q, e4_q;
   int         errors, checks, n8, n4, n;

   lcd_text_ctrl #(.CNT1MS(4), .COLS(16), .ROWS(2), .BUS4(0)) u8 (
      .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_char(wr_char), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cr8),
      .init_done(id8), .frame_done(fd8), .lcd_e(e8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_data(d8)
   );
   lcd_text_ctrl #(.CNT1MS(4), .COLS(16), .ROWS(2), .BUS4(1)) u4 (
      .clk(clk), .resetn(resetn), .wr_en(1'b0), .wr_row(2'd0), .wr_col(5'd0),
      .wr_char(8'd0), .cmd_valid(1'b0), .cmd_code(8'd0), .cmd_ready(cr4),
      .init_done(id4), .frame_done(fd4), .lcd_e(e4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_data(d4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction monitors: each rising lcd_e is compared against the next queued expectation
   always @(negedge clk) begin
      if (e8 && !e8_q && q8.size() > 0) begin
         t8 = q8.pop_front();
         checks++;
         if ({rw8, rs8, d8} !== {1'b0, t8}) begin
            errors++;
            $display("FAIL bus8_txn %0d: got rw=%0b rs=%0b data=%02h, want rw=0 rs=%0b data=%02h",
                     n8, rw8, rs8, d8, t8.rs, t8.d);
         end
         n8++;
      end
      e8_q = e8;
   end
   always @(negedge clk) begin
      if (e4 && !e4_q && q4.size() > 0) begin
         t4 = q4.pop_front();
         checks++;
         if ({rw4, rs4, d4} !== {1'b0, t4}) begin
            errors++;
            $display("FAIL bus4_txn %0d: got rw=%0b rs=%0b data=%02h, want rw=0 rs=%0b data=%02h",
                     n4, rw4, rs4, d4, t4.rs, t4.d);
         end
         n4++;
      end
      e4_q = e4;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   task automatic push8(input logic rs, input logic [7:0] d);
      q8.push_back({rs, d});
   endtask

   task automatic push_init8();
      push8(0, 8'h38); push8(0, 8'h08); push8(0, 8'h01); push8(0, 8'h06); push8(0, 8'h0C);
   endtask

   task automatic push_frame(input logic [7:0] r1c0, input bit with_cmd);
      push8(0, 8'h80);
      for (int c = 0; c < 16; c++) push8(1, 8'h20);
      if (with_cmd) push8(0, 8'h01);
      push8(0, 8'hC0);
      push8(1, r1c0);
      for (int c = 1; c < 16; c++) push8(1, 8'h20);
   endtask

   task automatic write_cell(input logic [1:0] r, input logic [4:0] c, input logic [7:0] ch);
      @(negedge clk);
      wr_en = 1'b1; wr_row = r; wr_col = c; wr_char = ch;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Counts cycles up to and including the next frame_done pulse
   task automatic wait_fd(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!fd8 && cnt < 5000);
      if (!fd8) chk("frame_done_timeout", 32'(cnt), 32'd0);
   endtask

   initial begin
      logic [3:0] nib [14];
      nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
      errors = 0; checks = 0; n8 = 0; n4 = 0;
      e8_q = 1'b0; e4_q = 1'b0;
      resetn = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_char = '0;
      cmd_valid = 1'b0; cmd_code = '0;
      for (int i = 0; i < 14; i++) q4.push_back({1'b0, nib[i], 4'h0});
      q4.push_back({1'b0, 8'h80}); q4.push_back({1'b0, 8'h00});
      q4.push_back({1'b1, 8'h20}); q4.push_back({1'b1, 8'h00});
      push_init8();
      push_frame(8'h41, 1'b0);
      push_frame(8'h41, 1'b1);
      repeat (3) @(negedge clk);
      chk("rst_lcd_e", e8, 0);
      chk("rst_lcd_data", d8, 0);
      chk("rst_init_done", id8, 0);
      chk("rst_cmd_ready", cr8, 0);
      chk("rst_frame_done", fd8, 0);
      resetn = 1'b1;
      repeat (19) @(posedge clk);
      #1 chk("e_before_first_slot", e8, 0);
      @(posedge clk);
      #1 chk("e_first_rise", e8, 1);
      chk("data_first", d8, 8'h38);
      chk("e4_first_rise", e4, 1);
      chk("data4_first", d4, 8'h30);
      repeat (75) @(posedge clk);
      #1 chk("init_done8_early", id8, 0);
      @(posedge clk);
      #1 chk("init_done8_slot6", id8, 1);
      chk("init_done4_early", id4, 0);
      repeat (143) @(posedge clk);
      #1 chk("init_done4_early2", id4, 0);
      @(posedge clk);
      #1 chk("init_done4_slot15", id4, 1);
      write_cell(2'd1, 5'd0, 8'h41);
      write_cell(2'd2, 5'd0, 8'h55);
      write_cell(2'd0, 5'd16, 8'h66);
      write_cell(2'd1, 5'd16, 8'h77);
      write_cell(2'd3, 5'd5, 8'h88);
      wait_fd(n);
      repeat (48) @(negedge clk);
      chk("cmd_ready_idle", cr8, 1);
      cmd_valid = 1'b1; cmd_code = 8'h01;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_code = 8'h00;
      chk("cmd_ready_pending", cr8, 0);
      repeat (80) @(negedge clk);
      chk("cmd_ready_still_pending", cr8, 0);
      wait_fd(n);
      chk("cmd_ready_after_cmd", cr8, 1);
      chk("q8_drained_pre_reset", q8.size(), 0);
      repeat (80) @(negedge clk);
      n = 0;
      while (!e8 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("e_high_before_reset", e8, 1);
      #1 resetn = 1'b0;
      #1 chk("async_rst_lcd_e", e8, 0);
      chk("async_rst_lcd_data", d8, 0);
      chk("async_rst_lcd_rs", rs8, 0);
      chk("async_rst_init_done", id8, 0);
      chk("async_rst_cmd_ready", cr8, 0);
      chk("async_rst_frame_done", fd8, 0);
      push_init8();
      push_frame(8'h20, 1'b0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      wait_fd(n);
      chk("first_frame_done_cycles", 32'(n), 32'd639);
      wait_fd(n);
      chk("frame_period_1", 32'(n), 32'd544);
      wait_fd(n);
      chk("frame_period_2", 32'(n), 32'd544);
      chk("q8_drained", q8.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
